// File: rtl/rv_mem_pkg.sv
// Shared encodings for the memory-stage store path.
//   SZ_*  : request size encodings (2'b11 is reserved and behaves as a word)
//   ST_*  : state encodings of the store read-modify-write sequencer
//   is_misaligned() : alignment rule shared by the sequencer and unit tests
package rv_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // Bytes are never misaligned; halves need addr[0] = 0; words and the
  // reserved size need addr[1:0] = 0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational merge of sub-word store data into an existing memory word.
// Ports:
//   old_word_i : word currently held in memory
//   wdata_i    : store data, sub-word data in the low bits
//   size_i     : SZ_BYTE / SZ_HALF / word (word and reserved pass wdata_i)
//   addr_lo_i  : byte address bits [1:0] selecting the lane
//   merged_o   : resulting word to write back
module store_merge
  import rv_mem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_store_rmw.sv
// Store front end for memory_stage. Loads and aligned word stores pass
// straight through; byte/half stores become a read (IDLE, stalled) followed
// by a merged word write (WRITE). Misaligned requests are flagged and
// misaligned stores are dropped.
// Ports:
//   clk, rst_n        : pipeline clock, async active-low reset
//   req_*             : memory op presented by MEM
//   mmo               : memory read data, combinational on malu
//   mwmem, malu, mb   : write enable / address / write data to memory_stage
//   stall             : freeze upstream during the read half of an RMW
//   misalign          : misaligned request this cycle
//   misalign_sticky   : any misalign since reset
//   rmw_count         : completed RMW stores, saturating
//
// state    | meaning
// ST_IDLE  | evaluate request; sub-word store reads old word and stalls
// ST_WRITE | write captured merged word; requests ignored
module mem_store_rmw
  import rv_mem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_wr,
  input  logic [1:0]       req_size,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [31:0]      mmo,
  output logic             mwmem,
  output logic [31:0]      malu,
  output logic [31:0]      mb,
  output logic             stall,
  output logic             misalign,
  output logic             misalign_sticky,
  output logic [CNT_W-1:0] rmw_count
);

  logic [0:0]       state_q, state_d;
  logic [31:0]      cap_addr_q, cap_addr_d;
  logic [31:0]      cap_word_q, cap_word_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        idle;
  logic        mis;
  logic        sub_store;
  logic        word_store;
  logic        mwmem_raw;
  logic        stall_raw;
  logic [31:0] aligned_addr;
  logic [31:0] merged;

  assign idle         = (state_q == ST_IDLE);
  assign aligned_addr = {req_addr[31:2], 2'b00};
  assign mis          = idle && req_valid && is_misaligned(req_size, req_addr[1:0]);
  assign sub_store    = idle && req_valid && req_wr && !mis && !req_size[1];
  assign word_store   = idle && req_valid && req_wr && !mis && req_size[1];

  store_merge u_store_merge (
    .old_word_i (mmo),
    .wdata_i    (req_wdata),
    .size_i     (req_size),
    .addr_lo_i  (req_addr[1:0]),
    .merged_o   (merged)
  );

  always_comb begin
    state_d    = state_q;
    cap_addr_d = cap_addr_q;
    cap_word_d = cap_word_q;
    sticky_d   = sticky_q | mis;
    cnt_d      = cnt_q;
    mwmem_raw  = 1'b0;
    stall_raw  = 1'b0;
    malu       = req_addr;
    mb         = req_wdata;

    if (state_q == ST_WRITE) begin
      mwmem_raw = 1'b1;
      malu      = cap_addr_q;
      mb        = cap_word_q;
      state_d   = ST_IDLE;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (sub_store) begin
      stall_raw  = 1'b1;
      malu       = aligned_addr;
      cap_addr_d = aligned_addr;
      cap_word_d = merged;
      state_d    = ST_WRITE;
    end else begin
      mwmem_raw = word_store;
    end
  end

  // Write enable and stall must be quiet while reset is held, even though
  // the request inputs may still be active.
  assign mwmem           = mwmem_raw & rst_n;
  assign stall           = stall_raw & rst_n;
  assign misalign        = mis;
  assign misalign_sticky = sticky_q;
  assign rmw_count       = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cap_addr_q <= '0;
      cap_word_q <= '0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cap_addr_q <= cap_addr_d;
      cap_word_q <= cap_word_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_store_rmw.sv
// Directed bench for mem_store_rmw with a small word memory standing in for
// memory_stage. The counter is built 2 bits wide so saturation is reachable.
module tb_mem_store_rmw;
  import rv_mem_pkg::*;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_wr;
  logic [1:0]       req_size;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [31:0]      mmo;
  logic             mwmem;
  logic [31:0]      malu;
  logic [31:0]      mb;
  logic             stall;
  logic             misalign;
  logic             misalign_sticky;
  logic [CNT_W-1:0] rmw_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;

  mem_store_rmw #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_wr          (req_wr),
    .req_size        (req_size),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .mmo             (mmo),
    .mwmem           (mwmem),
    .malu            (malu),
    .mb              (mb),
    .stall           (stall),
    .misalign        (misalign),
    .misalign_sticky (misalign_sticky),
    .rmw_count       (rmw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mmo = mem[malu[7:2]];

  always @(posedge clk) begin
    if (mwmem) mem[malu[7:2]] <= mb;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_wr    = wr;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    step();
    pl_en = 1'b0;
  endtask

  initial begin
    pl_en  = 1'b0;
    pl_idx = '0;
    pl_val = '0;
    rst_n  = 1'b0;
    // A sub-word store held during reset must not stall or write.
    drive(1'b1, 1'b1, SZ_BYTE, 32'h13, 32'hAA);
    #2;
    chk("rst_mwmem", {31'b0, mwmem}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_sticky", {31'b0, misalign_sticky}, 32'h0);
    chk("rst_count", {30'b0, rmw_count}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Aligned word store: same-cycle write.
    drive(1'b1, 1'b1, SZ_WORD, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("w_mwmem", {31'b0, mwmem}, 32'h1);
    chk("w_malu", malu, 32'h10);
    chk("w_mb", mb, 32'hDEADBEEF);
    chk("w_stall", {31'b0, stall}, 32'h0);
    step();
    drive(1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
    @(negedge clk);
    chk("ld_mwmem", {31'b0, mwmem}, 32'h0);
    chk("ld_stall", {31'b0, stall}, 32'h0);
    chk("ld_data", mmo, 32'hDEADBEEF);
    step();

    // Byte store to 0x13 over 0x11223344; garbage in WRITE cycle is ignored.
    preload(6'd4, 32'h11223344);
    drive(1'b1, 1'b1, SZ_BYTE, 32'h13, 32'h000000AA);
    @(negedge clk);
    chk("b_c0_stall", {31'b0, stall}, 32'h1);
    chk("b_c0_mwmem", {31'b0, mwmem}, 32'h0);
    chk("b_c0_malu", malu, 32'h10);
    step();
    drive(1'b1, 1'b1, SZ_WORD, 32'h12, 32'hFFFFFFFF);
    @(negedge clk);
    chk("b_c1_mwmem", {31'b0, mwmem}, 32'h1);
    chk("b_c1_malu", malu, 32'h10);
    chk("b_c1_mb", mb, 32'hAA223344);
    chk("b_c1_stall", {31'b0, stall}, 32'h0);
    chk("b_c1_mis", {31'b0, misalign}, 32'h0);
    step();
    drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    @(negedge clk);
    chk("b_count", {30'b0, rmw_count}, 32'h1);
    chk("b_mem", mem[4], 32'hAA223344);
    chk("b_sticky", {31'b0, misalign_sticky}, 32'h0);
    step();

    // Half store to 0x22 over zero.
    preload(6'd8, 32'h0);
    drive(1'b1, 1'b1, SZ_HALF, 32'h22, 32'h0000BEEF);
    @(negedge clk);
    chk("h_c0_stall", {31'b0, stall}, 32'h1);
    chk("h_c0_malu", malu, 32'h20);
    step();
    drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    @(negedge clk);
    chk("h_c1_mb", mb, 32'hBEEF0000);
    chk("h_c1_stall", {31'b0, stall}, 32'h0);
    step();
    @(negedge clk);
    chk("h_c2_stall", {31'b0, stall}, 32'h0);
    chk("h_mem", mem[8], 32'hBEEF0000);
    chk("h_count", {30'b0, rmw_count}, 32'h2);

    // Misaligned half store, then misaligned word load.
    step();
    drive(1'b1, 1'b1, SZ_HALF, 32'h21, 32'h00001234);
    @(negedge clk);
    chk("m_mis", {31'b0, misalign}, 32'h1);
    chk("m_mwmem", {31'b0, mwmem}, 32'h0);
    chk("m_stall", {31'b0, stall}, 32'h0);
    chk("m_sticky_pre", {31'b0, misalign_sticky}, 32'h0);
    step();
    drive(1'b1, 1'b0, SZ_WORD, 32'h22, 32'h0);
    @(negedge clk);
    chk("m_sticky", {31'b0, misalign_sticky}, 32'h1);
    chk("m_mem", mem[8], 32'hBEEF0000);
    chk("ml_mis", {31'b0, misalign}, 32'h1);
    chk("ml_malu", malu, 32'h22);
    chk("ml_stall", {31'b0, stall}, 32'h0);
    step();

    // Two byte stores to the same word with a bubble between; counter saturates at 3.
    preload(6'd12, 32'h0);
    drive(1'b1, 1'b1, SZ_BYTE, 32'h30, 32'h00000011);
    step();
    drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    step();
    drive(1'b1, 1'b1, SZ_BYTE, 32'h31, 32'h00000022);
    @(negedge clk);
    chk("bb_c0_stall", {31'b0, stall}, 32'h1);
    step();
    drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    @(negedge clk);
    chk("bb_c1_mb", mb, 32'h00002211);
    step();
    @(negedge clk);
    chk("bb_mem", mem[12], 32'h00002211);
    chk("bb_count_sat", {30'b0, rmw_count}, 32'h3);
    step();

    // Reset asserted during WRITE of a byte store to 0x40.
    preload(6'd16, 32'h55667788);
    drive(1'b1, 1'b1, SZ_BYTE, 32'h40, 32'h00000099);
    step();
    drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    chk("r_wr_mwmem", {31'b0, mwmem}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("r_mwmem", {31'b0, mwmem}, 32'h0);
    chk("r_stall", {31'b0, stall}, 32'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    chk("r_mem", mem[16], 32'h55667788);
    chk("r_count", {30'b0, rmw_count}, 32'h0);
    chk("r_sticky", {31'b0, misalign_sticky}, 32'h0);
    // Back in IDLE: a word store passes straight through.
    step();
    drive(1'b1, 1'b1, SZ_WORD, 32'h44, 32'hCAFEF00D);
    @(negedge clk);
    chk("r_idle_malu", malu, 32'h44);
    chk("r_idle_mb", mb, 32'hCAFEF00D);
    chk("r_idle_mwmem", {31'b0, mwmem}, 32'h1);
    step();
    drive(1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    @(negedge clk);
    chk("r_idle_mem", mem[17], 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
